sample_ctrl: RTL and testbench
==============================

# sample_ctrl

Batch controller and sample buffer upstream of the 1000-sample `counter` block. It captures one-cycle `data_ready` sample strobes into a 2-entry FIFO and forwards samples to the downstream datapath over a valid/ready handshake. It drives `cnt_up` once per forwarded sample and `clear` once per batch start. When the counter's `one_k_samples` flag rises, it ends the batch and reports `batch_done`; if a sample arrives while the buffer is full, it reports `err`.

## Interface
- `DATA_W`, 16, sample width in bits
- `clk`  in  1  system clock, all state updates on rising edge
- `n_rst`  in  1  reset; asynchronous, active-low
- `start`  in  1  one-cycle request to begin a new batch
- `data_ready`  in  1  one-cycle strobe; `sample_data` valid this cycle
- `sample_data`  in  DATA_W  incoming sample
- `out_ready`  in  1  downstream can accept a sample this cycle
- `one_k_samples`  in  1  rollover flag from `counter` (registered, high once 1000 counted)
- `sample_out`  out  DATA_W  head-of-FIFO sample
- `out_valid`  out  1  `sample_out` is valid
- `cnt_up`  out  1  count-enable to `counter`, one per forwarded sample
- `clear`  out  1  clear to `counter`, one cycle per batch start
- `batch_done`  out  1  batch of 1000 complete
- `err`  out  1  overflow latched

## Operation
- FSM states:
  - IDLE (reset state)
  - CLEAR
  - RUN
  - DONE
  - ERR
- Transitions:
  - IDLE: `start`=1 -> CLEAR; otherwise stay.
  - CLEAR: unconditional -> RUN. In CLEAR, `clear`=1, the FIFO is flushed (count=0) and `err` is cleared.
  - RUN: overflow -> ERR (takes priority); else `one_k_samples`=1 -> DONE; else stay.
  - DONE: `start`=1 -> CLEAR; otherwise stay.
  - ERR: `start`=1 -> CLEAR; otherwise stay.
- FIFO: 2 entries, with 2-bit occupancy count 0..2.
  - Push: on `data_ready`=1 in RUN when not full, or when full with a pop in the same cycle.
  - Pop: when `out_valid` and `out_ready` are both 1.
  - Simultaneous push and pop at any occupancy: count unchanged, order preserved (FIFO).
- Overflow: `data_ready`=1 in RUN, count=2, no pop this cycle. The sample is dropped, `err` is set at the next edge and the FSM enters ERR.
- `data_ready` in IDLE, CLEAR, DONE or ERR: sample dropped silently, no error.
- `out_valid` = (count≠0) AND state==RUN AND `one_k_samples`==0. The counter can never exceed 1000 within a batch.
- `cnt_up` = `out_valid` AND `out_ready`. It is combinational and coincides exactly with a pop.
- `sample_out` = FIFO head. Its value is don't-care when `out_valid`=0.
- `batch_done` = 1 in DONE only.
- `err` is registered: set on overflow, held through ERR, cleared in CLEAR.
- FIFO contents are retained in DONE and ERR, and discarded at the next CLEAR.
- `start` in RUN is ignored. A batch cannot be restarted mid-run except via reset.
- Reset values:
  - FSM: IDLE
  - FIFO count: 0
  - `clear`: 0
  - `cnt_up`: 0
  - `out_valid`: 0
  - `batch_done`: 0
  - `err`: 0
  - `sample_out`: 0
- Reset mid-batch: immediately aborts and returns to IDLE with outputs at reset values. It does not assert `clear`; the counter is reset by the shared `n_rst`.

## Timing
- `start` sampled at edge N: CLEAR during cycle N+1 (`clear`=1), RUN from N+2.
- `data_ready` sampled at edge N into an empty FIFO: `out_valid`=1 from cycle N+1. Input-to-output latency is 1 cycle.
- With `out_ready` held at 1, throughput is one sample per cycle. Back-to-back strobes never overflow.
- Counter rollover timing:
  - The 1000th `cnt_up` is sampled at edge M.
  - `counter` asserts `one_k_samples` in cycle M+1, and `out_valid` drops in that same cycle.
  - State is DONE from M+2, so `batch_done`=1 from cycle M+2.
- Overflow at edge N: `err`=1 and state ERR from cycle N+1.
- All outputs except `cnt_up` and `out_valid` are register outputs. Those two are combinational from state, count, `out_ready` and `one_k_samples`.

## Test plan
- Reset then `start`: `clear`=1 for exactly one cycle, 1 cycle after `start`; all other outputs 0; state reaches RUN.
- Single sample 0xA5A5 strobed with `out_ready`=1: `out_valid`=1 and `sample_out`=0xA5A5 one cycle later; exactly one `cnt_up` pulse.
- 1000 samples at one per cycle, `out_ready`=1, with the real `counter` attached:
  - exactly 1000 `cnt_up` pulses;
  - `batch_done`=1 two cycles after the last pulse;
  - 1001st strobe dropped, no `err`;
  - a second `start` re-clears and a new batch counts from 0.
- `out_ready`=0, three strobes 0x0001, 0x0002, 0x0003: first two buffered; third sets `err`=1 next cycle; state ERR; no `cnt_up`. Then `start`: `err`=0, FIFO empty.
- FIFO full with `out_ready`=1 and a strobe in the same cycle: no error; outputs in order 0x0001, 0x0002, new sample.
- Assert `n_rst`=0 mid-batch with the FIFO holding 2 samples: all outputs 0 immediately; after release, state IDLE and `data_ready` is ignored until `start`.

Source files
------------

// File: rtl/sample_ctrl.sv
// Batch controller and 2-entry sample buffer in front of the 1000-sample counter.
// Sequences clear/run/done/err and forwards samples over a valid/ready handshake.
module sample_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              data_ready,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              out_ready,
  input  logic              one_k_samples,
  output logic [DATA_W-1:0] sample_out,
  output logic              out_valid,
  output logic              cnt_up,
  output logic              clear,
  output logic              batch_done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DONE, ERR} state_t;

  state_t                 state;
  logic [1:0][DATA_W-1:0] mem;
  logic                   rd_ptr, wr_ptr;
  logic [1:0]             count;
  logic                   in_run, full, pop, push, overflow;

  assign in_run     = (state == RUN);
  assign full       = (count == 2'd2);
  // Gating on one_k_samples stops the counter from ever seeing a 1001st count.
  assign out_valid  = (count != 2'd0) && in_run && !one_k_samples;
  assign pop        = out_valid && out_ready;
  assign cnt_up     = pop;
  assign push       = data_ready && in_run && (!full || pop);
  assign overflow   = data_ready && in_run && full && !pop;
  assign sample_out = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      mem        <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      clear      <= 1'b0;
      batch_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      clear <= 1'b0;
      if (push) begin
        mem[wr_ptr] <= sample_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;

      case (state)
        IDLE, DONE, ERR: begin
          // Flush on entry so the FIFO is already empty while clear is high.
          if (start) begin
            state      <= CLEAR;
            clear      <= 1'b1;
            err        <= 1'b0;
            batch_done <= 1'b0;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
          end
        end
        CLEAR: state <= RUN;
        RUN: begin
          if (overflow) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (one_k_samples) begin
            state      <= DONE;
            batch_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_ctrl.sv
// Directed bench for sample_ctrl with a behavioural 1000-sample counter attached.
module tb_sample_ctrl;

  logic        clk = 1'b0;
  logic        n_rst, start, data_ready, out_ready;
  logic [15:0] sample_data, sample_out;
  logic        out_valid, cnt_up, clear, batch_done, err;
  logic        one_k;
  int          kcnt;
  int          pulses = 0;
  int          checks = 0;
  int          failures = 0;
  int          p;

  always #5 clk = ~clk;

  sample_ctrl #(.DATA_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .data_ready(data_ready),
    .sample_data(sample_data), .out_ready(out_ready), .one_k_samples(one_k),
    .sample_out(sample_out), .out_valid(out_valid), .cnt_up(cnt_up),
    .clear(clear), .batch_done(batch_done), .err(err)
  );

  // Counter model: registered flag high once 1000 counts seen, cleared by clear.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      kcnt  <= 0;
      one_k <= 1'b0;
    end else if (clear) begin
      kcnt  <= 0;
      one_k <= 1'b0;
    end else if (cnt_up) begin
      kcnt <= kcnt + 1;
      if (kcnt == 999) one_k <= 1'b1;
    end
  end

  always @(posedge clk) if (n_rst && cnt_up) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; data_ready = 1'b0; sample_data = '0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cnt_up", cnt_up, 0);
    chk("rst_clear", clear, 0);
    chk("rst_batch_done", batch_done, 0);
    chk("rst_err", err, 0);
    chk("rst_sample_out", sample_out, 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    tick();
    chk("idle_clear", clear, 0);

    // start -> CLEAR for one cycle -> RUN
    start = 1'b1; tick(); start = 1'b0; #1;
    chk("clear_pulse", clear, 1);
    chk("clear_bd", batch_done, 0);
    chk("clear_err", err, 0);
    chk("clear_ov", out_valid, 0);
    tick();
    chk("clear_once", clear, 0);

    // single sample, 1-cycle latency
    p = pulses;
    data_ready = 1'b1; sample_data = 16'hA5A5; out_ready = 1'b1; #1;
    chk("single_cu_early", cnt_up, 0);
    tick(); data_ready = 1'b0; #1;
    chk("single_ov", out_valid, 1);
    chk("single_data", sample_out, 16'hA5A5);
    chk("single_cu", cnt_up, 1);
    tick();
    chk("single_ov_after", out_valid, 0);
    chk("single_pulses", pulses - p, 1);

    // full FIFO with simultaneous push/pop; start in RUN ignored
    p = pulses; out_ready = 1'b0;
    data_ready = 1'b1; sample_data = 16'h0001; tick();
    sample_data = 16'h0002; tick();
    out_ready = 1'b1; sample_data = 16'h0003; start = 1'b1; #1;
    chk("full_ov", out_valid, 1);
    chk("full_head1", sample_out, 16'h0001);
    chk("full_cu", cnt_up, 1);
    tick(); data_ready = 1'b0; start = 1'b0; #1;
    chk("run_start_ignored", clear, 0);
    chk("full_no_err", err, 0);
    chk("full_head2", sample_out, 16'h0002);
    tick();
    chk("full_head3", sample_out, 16'h0003);
    chk("full_ov3", out_valid, 1);
    tick();
    chk("full_drained", out_valid, 0);
    chk("full_pulses", pulses - p, 3);

    // overflow with out_ready low
    p = pulses; out_ready = 1'b0;
    data_ready = 1'b1; sample_data = 16'h0001; tick();
    sample_data = 16'h0002; tick();
    chk("ovf_buf_ov", out_valid, 1);
    chk("ovf_buf_head", sample_out, 16'h0001);
    chk("ovf_buf_cu", cnt_up, 0);
    chk("ovf_pre_err", err, 0);
    sample_data = 16'h0003; tick(); data_ready = 1'b0; #1;
    chk("ovf_err", err, 1);
    chk("ovf_state_ov", out_valid, 0);
    chk("ovf_bd", batch_done, 0);
    tick();
    chk("ovf_err_held", err, 1);
    chk("ovf_pulses", pulses - p, 0);
    start = 1'b1; tick(); start = 1'b0; #1;
    chk("ovf_restart_err", err, 0);
    chk("ovf_restart_clear", clear, 1);
    out_ready = 1'b1;
    tick();
    chk("ovf_fifo_empty", out_valid, 0);

    // full batch: 1001 back-to-back strobes, out_ready high
    p = pulses;
    for (int i = 0; i <= 1000; i++) begin
      data_ready = 1'b1; sample_data = 16'(i);
      tick();
    end
    data_ready = 1'b0; #1;
    chk("batch_pulses", pulses - p, 1000);
    chk("batch_ov_drop", out_valid, 0);
    chk("batch_cu_stop", cnt_up, 0);
    chk("batch_bd_early", batch_done, 0);
    chk("batch_err_pre", err, 0);
    tick();
    chk("batch_done", batch_done, 1);
    chk("batch_no_err", err, 0);
    chk("batch_done_ov", out_valid, 0);
    chk("batch_pulses_final", pulses - p, 1000);

    // restart: counter re-cleared, new batch counts from 0
    start = 1'b1; tick(); start = 1'b0; #1;
    chk("rebatch_clear", clear, 1);
    chk("rebatch_bd", batch_done, 0);
    tick();
    data_ready = 1'b1; sample_data = 16'h0007; tick(); data_ready = 1'b0; #1;
    chk("rebatch_cu", cnt_up, 1);
    chk("rebatch_data", sample_out, 16'h0007);
    tick();
    chk("rebatch_kcnt", kcnt, 1);
    chk("rebatch_onek", one_k, 0);

    // reset mid-batch with two samples buffered
    out_ready = 1'b0;
    data_ready = 1'b1; sample_data = 16'h0011; tick();
    sample_data = 16'h0022; tick(); data_ready = 1'b0; #1;
    chk("mid_ov", out_valid, 1);
    n_rst = 1'b0; out_ready = 1'b1; #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_cu", cnt_up, 0);
    chk("mid_rst_data", sample_out, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_clear", clear, 0);
    chk("mid_rst_bd", batch_done, 0);
    tick(); n_rst = 1'b1;
    data_ready = 1'b1; sample_data = 16'h0033; tick(); data_ready = 1'b0; #1;
    chk("idle_ignore_ov", out_valid, 0);
    chk("idle_ignore_err", err, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("post_rst_run_ov", out_valid, 0);
    chk("post_rst_run_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
